baccarat_fsm: RTL

Control state machine for the baccarat game. It sits directly upstream of the card datapath and drives that block's six load strobes, one per button press, in the order P1, D1, P2, D2. It reads back pscore, dscore and pcard3 to apply the third-card rules. When the hand is complete it drives the player-win and dealer-win lights.

---
 rtl/baccarat_fsm.sv | 125 ++++++++++++
 1 files changed

// File: rtl/baccarat_fsm.sv
// Baccarat hand sequencer: turns step-button presses into card load strobes,
// applies the third-card rules and latches the win lights at the end of the hand.
module baccarat_fsm (
    input  logic       clk,
    input  logic       resetb,
    input  logic       key,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    // state    | meaning
    // S_P1     | waiting for press to deal player card 1
    // S_D1     | waiting for press to deal dealer card 1
    // S_P2     | waiting for press to deal player card 2
    // S_D2     | waiting for press to deal dealer card 2
    // S_EVAL   | press applies natural / player third-card rule
    // S_BANK   | press applies dealer third-card rule using player's third card
    // S_SETTLE | one cycle for datapath scores to settle, lights latch on exit
    // S_DONE   | hand finished, presses ignored until reset
    typedef enum logic [2:0] {
        S_P1, S_D1, S_P2, S_D2, S_EVAL, S_BANK, S_SETTLE, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic       key_q;
    logic       armed;
    logic       press;
    logic       dealer_draw;
    logic [3:0] v;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state            <= S_P1;
            key_q            <= 1'b1;
            armed            <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            state <= state_nxt;
            key_q <= key;
            armed <= armed | key;
            if (state == S_SETTLE) begin
                player_win_light <= (pscore >= dscore);
                dealer_win_light <= (dscore >= pscore);
            end
        end
    end

    // armed blocks a key that was already low when reset released from
    // counting as a press until it has been seen high at least once.
    assign press = resetb & key_q & ~key & armed;

    assign v = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

    always_comb begin
        dealer_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
            4'd3:             dealer_draw = (v != 4'd8);
            4'd4:             dealer_draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             dealer_draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             dealer_draw = (v >= 4'd6) && (v <= 4'd7);
            default:          dealer_draw = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        case (state)
            S_P1: if (press) begin
                load_pcard1 = 1'b1;
                state_nxt   = S_D1;
            end
            S_D1: if (press) begin
                load_dcard1 = 1'b1;
                state_nxt   = S_P2;
            end
            S_P2: if (press) begin
                load_pcard2 = 1'b1;
                state_nxt   = S_D2;
            end
            S_D2: if (press) begin
                load_dcard2 = 1'b1;
                state_nxt   = S_EVAL;
            end
            S_EVAL: if (press) begin
                if (pscore >= 4'd8 || dscore >= 4'd8) begin
                    state_nxt = S_SETTLE;
                end else if (pscore <= 4'd5) begin
                    load_pcard3 = 1'b1;
                    state_nxt   = S_BANK;
                end else begin
                    load_dcard3 = (dscore <= 4'd5);
                    state_nxt   = S_SETTLE;
                end
            end
            S_BANK: if (press) begin
                load_dcard3 = dealer_draw;
                state_nxt   = S_SETTLE;
            end
            S_SETTLE: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_P1;
        endcase
    end

    assign hand_done = (state == S_DONE);

endmodule
